// File: rtl/load_store_unit.sv
// Data-memory initiator: alignment check, big-endian lanes, load extension, sub-word RMW.
// Define LSU_SUBWORD_EN to build byte/halfword support; otherwise every access is a word.
module load_store_unit (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req,
    input  logic        We,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] RData,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemRead_n,
    output logic        MemWrite_n,
    input  logic [31:0] MemRData
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_read_n_q, mem_read_n_d;
    logic        mem_write_n_q, mem_write_n_d;
    logic        err_q, err_d;
    logic        accept, misaligned, direct_wr, rd_store;
    logic [31:0] load_val, store_val;

    assign accept = Req && (state_q == S_IDLE);

`ifdef LSU_SUBWORD_EN
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  sh_b, sh_h;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign misaligned = Size[1] ? (Addr[1:0] != 2'b00) : (Size[0] & Addr[0]);
    assign direct_wr  = We & Size[1];
    assign rd_store   = we_q;

    // Lane k sits at bits [31-8k -: 8], so the shift is (3-k)*8.
    assign sh_b   = {~off_q, 3'b000};
    assign sh_h   = {~off_q[1], 4'b0000};
    assign lane_b = 8'(MemRData >> sh_b);
    assign lane_h = 16'(MemRData >> sh_h);

    always_comb begin
        load_val  = MemRData;
        store_val = MemRData;
        unique case (size_q)
            2'b00: begin
                load_val  = {{24{~uns_q & lane_b[7]}}, lane_b};
                store_val = (MemRData & ~(32'h0000_00FF << sh_b))
                          | ({24'd0, mem_wdata_q[7:0]} << sh_b);
            end
            2'b01: begin
                load_val  = {{16{~uns_q & lane_h[15]}}, lane_h};
                store_val = (MemRData & ~(32'h0000_FFFF << sh_h))
                          | ({16'd0, mem_wdata_q[15:0]} << sh_h);
            end
            default: ;
        endcase
    end

    always_comb begin
        we_d   = we_q;
        uns_d  = uns_q;
        size_d = size_q;
        off_d  = off_q;
        if (accept) begin
            we_d   = We;
            uns_d  = Unsigned;
            size_d = Size;
            off_d  = Addr[1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            we_q   <= 1'b0;
            uns_q  <= 1'b0;
            size_q <= 2'b00;
            off_q  <= 2'b00;
        end else begin
            we_q   <= we_d;
            uns_q  <= uns_d;
            size_q <= size_d;
            off_q  <= off_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{Size, Unsigned};
    assign misaligned = (Addr[1:0] != 2'b00);
    assign direct_wr  = We;
    assign rd_store   = 1'b0;
    assign load_val   = MemRData;
    assign store_val  = MemRData;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misaligned)     state_d = S_FIN;
                    else if (direct_wr) state_d = S_WR;
                    else                state_d = S_RD;
                end
            end
            S_RD:    state_d = rd_store ? S_WR : S_FIN;
            S_WR:    state_d = S_FIN;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes follow the next state so they come straight from flops.
    always_comb begin
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        mem_read_n_d  = (state_d != S_RD);
        mem_write_n_d = (state_d != S_WR);
        if (accept) begin
            mem_addr_d  = {Addr[31:2], 2'b00};
            mem_wdata_d = WData;
            err_d       = misaligned;
        end
        if (state_q == S_RD) begin
            if (rd_store) mem_wdata_d = store_val;
            else          rdata_d     = load_val;
        end
        if (state_q == S_FIN) err_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            mem_read_n_q  <= 1'b1;
            mem_write_n_q <= 1'b1;
            err_q         <= 1'b0;
        end else begin
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            mem_read_n_q  <= mem_read_n_d;
            mem_write_n_q <= mem_write_n_d;
            err_q         <= err_d;
        end
    end

    assign Busy       = (state_q != S_IDLE);
    assign Done       = (state_q == S_FIN);
    assign Err        = err_q;
    assign RData      = rdata_q;
    assign MemAddr    = mem_addr_q;
    assign MemWData   = mem_wdata_q;
    assign MemRead_n  = mem_read_n_q;
    assign MemWrite_n = mem_write_n_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, byte-level reference model,
// directed scenarios and randomized accesses.
module tb_load_store_unit;
`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset, Req, We, Unsigned;
    logic [1:0]  Size;
    logic [31:0] Addr, WData;
    logic        Busy, Done, Err;
    logic [31:0] RData, MemAddr, MemWData, MemRData;
    logic        MemRead_n, MemWrite_n;

    logic [7:0]  mem [0:63];
    logic [7:0]  ref_mem [0:63];
    logic [31:0] exp_rdata = 32'h0;
    logic [5:0]  rb;
    int          wr_count = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    load_store_unit dut (
        .CLK(CLK), .Reset(Reset), .Req(Req), .We(We), .Size(Size),
        .Unsigned(Unsigned), .Addr(Addr), .WData(WData), .Busy(Busy),
        .Done(Done), .Err(Err), .RData(RData), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemRead_n(MemRead_n),
        .MemWrite_n(MemWrite_n), .MemRData(MemRData)
    );

    always #5 CLK = ~CLK;

    assign rb = {MemAddr[5:2], 2'b00};
    assign MemRData = MemRead_n ? 32'hA5A5_A5A5
        : {mem[rb], mem[rb + 6'd1], mem[rb + 6'd2], mem[rb + 6'd3]};

    always @(negedge CLK) begin
        if (MemWrite_n === 1'b0) begin
            for (int i = 0; i < 4; i++) mem[rb + 6'(i)] = MemWData[8*(3-i) +: 8];
            wr_count++;
        end
    end

    // Reference: byte-level memory semantics with big-endian byte order.
    task automatic ref_access(input bit we, input logic [1:0] size,
                              input bit uns, input logic [31:0] addr,
                              input logic [31:0] wdata, output bit err,
                              output int lat, output int nwr, output int nrd);
        int n;
        int base;
        logic [31:0] val;
        n    = !SUBWORD ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        base = int'(addr[5:0]);
        err  = 1'b0;
        lat  = 1;
        nwr  = 0;
        nrd  = 1;
        if ((base % n) != 0) begin
            err = 1'b1;
            lat = 0;
            nrd = 0;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wdata >> (8 * (n - 1 - i)));
            nwr = 1;
            lat = (n == 4) ? 1 : 2;
            nrd = (n == 4) ? 0 : 1;
        end else begin
            val = 32'h0;
            for (int i = 0; i < n; i++) val = (val << 8) | {24'd0, ref_mem[base + i]};
            if (!uns && n == 1) val = {{24{val[7]}}, val[7:0]};
            if (!uns && n == 2) val = {{16{val[15]}}, val[15:0]};
            exp_rdata = val;
        end
    endtask

    task automatic do_op(input string name, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bit e_err;
        int e_lat, e_wr, e_rd, k, rd_seen, addr_bad, wr0;
        bit done_seen;
        logic [5:0] b;
        ref_access(we, size, uns, addr, wdata, e_err, e_lat, e_wr, e_rd);
        b = {addr[5:2], 2'b00};
        @(negedge CLK);
        Req = 1'b1; We = we; Size = size; Unsigned = uns; Addr = addr; WData = wdata;
        wr0 = wr_count;
        @(posedge CLK); #1;
        Req = 1'b0; We = $urandom; Size = 2'($urandom); Unsigned = $urandom;
        Addr = $urandom; WData = $urandom;
        k = 0; rd_seen = 0; addr_bad = 0; done_seen = 1'b0;
        while (k < 8) begin
            if (MemRead_n === 1'b0) rd_seen++;
            if ((MemRead_n === 1'b0 || MemWrite_n === 1'b0) &&
                MemAddr !== {addr[31:2], 2'b00}) addr_bad++;
            if (Done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            @(posedge CLK); #1;
            k++;
        end
        n_cmp++;
        if (!done_seen || k != e_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d (done=%0b) want %0d", name, k, done_seen, e_lat);
        end
        n_cmp++;
        if (Err !== e_err) begin
            n_bad++;
            $display("FAIL %s err: got %b want %b", name, Err, e_err);
        end
        n_cmp++;
        if (Busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_at_done: got %b want 1", name, Busy);
        end
        n_cmp++;
        if (RData !== exp_rdata) begin
            n_bad++;
            $display("FAIL %s rdata: got %h want %h", name, RData, exp_rdata);
        end
        n_cmp++;
        if (wr_count - wr0 != e_wr) begin
            n_bad++;
            $display("FAIL %s writes: got %0d want %0d", name, wr_count - wr0, e_wr);
        end
        n_cmp++;
        if (rd_seen != e_rd || addr_bad != 0) begin
            n_bad++;
            $display("FAIL %s reads/addr: got %0d rd cycles, %0d bad addr want %0d, 0",
                     name, rd_seen, addr_bad, e_rd);
        end
        n_cmp++;
        if ({mem[b], mem[b+6'd1], mem[b+6'd2], mem[b+6'd3]} !==
            {ref_mem[b], ref_mem[b+6'd1], ref_mem[b+6'd2], ref_mem[b+6'd3]}) begin
            n_bad++;
            $display("FAIL %s mem_word: got %h want %h", name,
                     {mem[b], mem[b+6'd1], mem[b+6'd2], mem[b+6'd3]},
                     {ref_mem[b], ref_mem[b+6'd1], ref_mem[b+6'd2], ref_mem[b+6'd3]});
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_done: got busy=%b done=%b want 0,0", name, Busy, Done);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if ({Busy, Done, Err, MemRead_n, MemWrite_n} !== 5'b00011 ||
            MemAddr !== 32'h0 || MemWData !== 32'h0 || RData !== 32'h0) begin
            n_bad++;
            $display("FAIL %s reset_outputs: got b%b d%b e%b rn%b wn%b a%h w%h r%h want 0,0,0,1,1,0,0,0",
                     name, Busy, Done, Err, MemRead_n, MemWrite_n, MemAddr, MemWData, RData);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK); #1;
        check_reset_outputs("reset_release");
    endtask

    task automatic test_word();
        do_op("store_word", 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1122_3344);
        do_op("load_word", 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
        n_cmp++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h1122_3344) begin
            n_bad++;
            $display("FAIL word_bytes: got %h want 11223344", {mem[8], mem[9], mem[10], mem[11]});
        end
    endtask

    task automatic test_load_ext();
        do_op("setup_ext", 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h807F_01FE);
        do_op("lb_signed_08", 1'b0, 2'b00, 1'b0, 32'h0000_0008, 32'h0);
        do_op("lbu_0b", 1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0);
        do_op("lh_signed_0a", 1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0);
        do_op("lhu_08", 1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0);
        do_op("lb_signed_09", 1'b0, 2'b00, 1'b0, 32'h0000_0009, 32'h0);
    endtask

    task automatic test_byte_store();
        do_op("setup_sb", 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1122_3344);
        do_op("store_byte_09", 1'b1, 2'b00, 1'b0, 32'h0000_0009, 32'h5555_55AB);
        do_op("store_half_0e", 1'b1, 2'b01, 1'b0, 32'h0000_000E, 32'h9999_BEEF);
        do_op("reload_08", 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
    endtask

    task automatic test_misaligned();
        do_op("load_half_05", 1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'h0);
        do_op("store_word_06", 1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'hDEAD_BEEF);
        do_op("load_word_size3_01", 1'b0, 2'b11, 1'b0, 32'h0000_0001, 32'h0);
    endtask

    task automatic test_busy_ignore();
        bit e_err;
        int e_lat, e_wr, e_rd, wr0;
        ref_access(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, e_err, e_lat, e_wr, e_rd);
        @(negedge CLK);
        Req = 1'b1; We = 1'b0; Size = 2'b10; Addr = 32'h0000_0010;
        wr0 = wr_count;
        @(posedge CLK); #1;
        We = 1'b1; Addr = 32'h0000_0014; WData = 32'hCAFE_F00D;
        @(posedge CLK); #1;
        n_cmp++;
        if (Done !== 1'b1 || RData !== exp_rdata) begin
            n_bad++;
            $display("FAIL busy_ignore done: got done=%b rdata=%h want 1 %h", Done, RData, exp_rdata);
        end
        @(posedge CLK); #1;
        Req = 1'b0;
        n_cmp++;
        if (Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ignore fin_req: got busy=%b want 0", Busy);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (Busy !== 1'b0 || wr_count != wr0 ||
            {mem[20], mem[21], mem[22], mem[23]} !==
            {ref_mem[20], ref_mem[21], ref_mem[22], ref_mem[23]}) begin
            n_bad++;
            $display("FAIL busy_ignore no_write: got busy=%b writes=%0d want 0 0",
                     Busy, wr_count - wr0);
        end
        do_op("after_ignore_store", 1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h0BAD_F00D);
    endtask

    task automatic test_reset_mid(input string name, input logic [1:0] size,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input bit write_lands);
        bit e_err;
        int e_lat, e_wr, e_rd, wr0;
        logic [5:0] b;
        b = {addr[5:2], 2'b00};
        if (write_lands) ref_access(1'b1, size, 1'b0, addr, wdata, e_err, e_lat, e_wr, e_rd);
        else e_wr = 0;
        @(negedge CLK);
        Req = 1'b1; We = 1'b1; Size = size; Addr = addr; WData = wdata;
        wr0 = wr_count;
        @(posedge CLK); #1;
        Req = 1'b0;
        Reset = 1'b1;
        @(posedge CLK); #1;
        exp_rdata = 32'h0;
        check_reset_outputs(name);
        n_cmp++;
        if (wr_count - wr0 != e_wr ||
            {mem[b], mem[b+6'd1], mem[b+6'd2], mem[b+6'd3]} !==
            {ref_mem[b], ref_mem[b+6'd1], ref_mem[b+6'd2], ref_mem[b+6'd3]}) begin
            n_bad++;
            $display("FAIL %s write: got %0d writes word %h want %0d word %h", name,
                     wr_count - wr0, {mem[b], mem[b+6'd1], mem[b+6'd2], mem[b+6'd3]}, e_wr,
                     {ref_mem[b], ref_mem[b+6'd1], ref_mem[b+6'd2], ref_mem[b+6'd3]});
        end
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_rd();
        do_op("pre_reset_load", 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
        test_reset_mid("reset_in_rd", 2'b00, 32'h0000_0020, 32'h0000_00C3, !SUBWORD);
    endtask

    task automatic test_reset_wr();
        do_op("pre_reset_load2", 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
        test_reset_mid("reset_in_wr", 2'b10, 32'h0000_0024, 32'h7654_3210, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            a = $urandom & 32'hFF00_003F;
            do_op($sformatf("rand%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
                  a, $urandom);
        end
    endtask

    initial begin
        int diff;
        Reset = 1'b1; Req = 1'b0; We = 1'b0; Size = 2'b00; Unsigned = 1'b0;
        Addr = 32'h0; WData = 32'h0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_word();
        test_load_ext();
        test_byte_store();
        test_misaligned();
        test_busy_ignore();
        test_reset_rd();
        test_reset_wr();
        test_random();
        diff = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diff++;
        n_cmp++;
        if (diff != 0) begin
            n_bad++;
            $display("FAIL final_memory: got %0d differing bytes want 0", diff);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the CPU's data-memory port. It accepts one load or store request at a time from the execute/memory stage and drives the byte-addressed, big-endian, word-wide data memory. That memory has active-low read/write strobes, a combinational read and a negedge write. The unit handles alignment checking, sub-word lane selection, load sign/zero extension and read-modify-write for sub-word stores, then returns a one-cycle completion pulse.

## Interface
- No parameters; all widths fixed at 32 bits.
- CLK  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high; sampled on posedge CLK.
- Req  in  1  request strobe; accepted only when Busy=0.
- We  in  1  1 = store, 0 = load.
- Size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- Unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Addr  in  32  byte address.
- WData  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- Busy  out  1  high from the cycle after acceptance through the Done cycle.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  misaligned access; valid with Done.
- RData  out  32  extended load result; valid with Done and held until the next load completes.
- MemAddr  out  32  word-aligned address to memory (Addr & ~3).
- MemWData  out  32  write word to memory.
- MemRead_n  out  1  0 = read, 1 = idle (memory output high-Z).
- MemWrite_n  out  1  0 = write at the next negedge CLK, 1 = no operation.
- MemRData  in  32  memory read word (combinational).

## Operation
- All memory-side outputs are registered, so MemWrite_n never glitches.
- Byte lanes are big-endian. Lane k = Addr[1:0] maps to bits [31-8k:24-8k]. Halfword at offset 0 maps to [31:16]; at offset 2 it maps to [15:0].
- Misaligned accesses: a halfword with Addr[0]=1, or a word with Addr[1:0]≠0. These cause no memory access and raise Err=1 with Done. RData is unchanged.
- FSM states:
  - IDLE: if Req, latch the request and go to RD (any load, or a sub-word store), WR (word store), or FIN with Err (misaligned).
  - RD: MemRead_n=0. Capture MemRData at the posedge. A load then extends the selected lane into RData and goes to FIN. A sub-word store merges WData into the selected lane of the captured word, loads the result into MemWData, and goes to WR.
  - WR: MemWrite_n=0 for exactly one cycle; then go to FIN.
  - FIN: Done=1; return to IDLE.
- Busy = (state ≠ IDLE). A Req while Busy is ignored; it is not queued.
- Reset values: state IDLE; MemRead_n=1, MemWrite_n=1; MemAddr, MemWData and RData = 0; Busy, Done and Err = 0.
- Reset asserted during a WR cycle does not cancel that cycle's negedge write. Reset during RD of a sub-word store suppresses the write entirely.

## Timing
- Request accepted at posedge T0.
- Word load: RD in cycle T0→T1; Done at cycle T1→T2.
- Word store: WR in cycle T0→T1, with the memory written at that cycle's negedge; Done at T1→T2.
- Sub-word store: RD in T0→T1, WR in T1→T2, Done at T2→T3.
- Misaligned access: Done and Err in cycle T0→T1.
- Minimum request spacing is 3 cycles (word access) or 4 cycles (sub-word store).

## Configuration
- LSU_SUBWORD_EN defined: byte and halfword loads and stores are supported as described above.
- LSU_SUBWORD_EN undefined: Size and Unsigned are ignored and every access is a word access. Word-alignment checking still applies. The RD-before-WR merge path and the extension logic are not built, and stores always go IDLE→WR→FIN.

## Test plan
- Store word 0x11223344 to 0x08, then load word from 0x08 → bytes 8..11 are 11,22,33,44; RData=0x11223344; Done two cycles after Req.
- With mem[0x08..0x0B]=80,7F,01,FE, load signed byte at 0x08 → 0xFFFFFF80; unsigned byte at 0x0B → 0x000000FE; signed half at 0x0A → 0x000001FE.
- Store byte 0xAB to 0x09 over word 0x11223344 → word becomes 0x11AB3344; MemWrite_n low exactly one cycle; Done at T3.
- Load half from 0x05 → Done and Err in cycle T0→T1; MemRead_n and MemWrite_n stay 1; RData unchanged.
- Issue Req while Busy, then a second Req in the FIN cycle → both ignored; the next Req is accepted only in IDLE.
- Reset during RD of a sub-word store → no write occurs, all outputs return to reset values next cycle. Reset during WR → the memory write still lands.
